// File: rtl/decode_stage.sv
// Registered RV32I/RV64I decode stage with optional M-extension decode and a
// 2-entry skid buffer so fetch and execute both run at full rate under backpressure.
module decode_stage #(
    parameter  int XLEN = 32,
    parameter  int EN_M = 0,
    localparam int OP_W = (EN_M != 0) ? 45 : 37
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic              out_rd_valid,
    output logic              out_rs1_valid,
    output logic              out_rs2_valid,
    output logic              out_imm_valid,
    output logic [XLEN-1:0]   out_imm,
    output logic [OP_W-1:0]   out_op,
    output logic              out_illegal
);

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IALU   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            rd_v;
        logic            rs1_v;
        logic            rs2_v;
        logic            imm_v;
        logic [XLEN-1:0] imm;
        logic [OP_W-1:0] op;
        logic            illegal;
    } dec_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

    logic [6:0]        opc;
    logic [2:0]        f3;
    logic [6:0]        f7;
    logic [36:0]       base_op;
    logic [OP_W-1:0]   dec_op;
    logic              is_r, is_i, is_s, is_b, is_u, is_j;
    logic              dec_ill;
    logic signed [31:0] imm32;
    dec_t              dec;

    assign opc = in_instr[6:0];
    assign f3  = in_instr[14:12];
    assign f7  = in_instr[31:25];

    always_comb begin
        base_op = '0;
        case (opc)
            OPC_R: begin
                if (f7 == 7'h00) begin
                    case (f3)
                        3'd0: base_op[0] = 1'b1;
                        3'd1: base_op[5] = 1'b1;
                        3'd2: base_op[8] = 1'b1;
                        3'd3: base_op[9] = 1'b1;
                        3'd4: base_op[2] = 1'b1;
                        3'd5: base_op[6] = 1'b1;
                        3'd6: base_op[3] = 1'b1;
                        default: base_op[4] = 1'b1;
                    endcase
                end else if (f7 == 7'h20) begin
                    if (f3 == 3'd0) base_op[1] = 1'b1;
                    if (f3 == 3'd5) base_op[7] = 1'b1;
                end
            end
            OPC_IALU: begin
                case (f3)
                    3'd0: base_op[10] = 1'b1;
                    3'd1: base_op[14] = (f7 == 7'h00);
                    3'd2: base_op[17] = 1'b1;
                    3'd3: base_op[18] = 1'b1;
                    3'd4: base_op[11] = 1'b1;
                    3'd5: begin
                        base_op[15] = (f7 == 7'h00);
                        base_op[16] = (f7 == 7'h20);
                    end
                    3'd6: base_op[12] = 1'b1;
                    default: base_op[13] = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                case (f3)
                    3'd0: base_op[19] = 1'b1;
                    3'd1: base_op[20] = 1'b1;
                    3'd2: base_op[21] = 1'b1;
                    3'd4: base_op[22] = 1'b1;
                    3'd5: base_op[23] = 1'b1;
                    default: ;
                endcase
            end
            OPC_STORE: begin
                case (f3)
                    3'd0: base_op[24] = 1'b1;
                    3'd1: base_op[25] = 1'b1;
                    3'd2: base_op[26] = 1'b1;
                    default: ;
                endcase
            end
            OPC_BRANCH: begin
                case (f3)
                    3'd0: base_op[27] = 1'b1;
                    3'd1: base_op[28] = 1'b1;
                    3'd4: base_op[29] = 1'b1;
                    3'd5: base_op[30] = 1'b1;
                    3'd6: base_op[31] = 1'b1;
                    3'd7: base_op[32] = 1'b1;
                    default: ;
                endcase
            end
            OPC_JAL:   base_op[33] = 1'b1;
            OPC_JALR:  base_op[34] = (f3 == 3'd0);
            OPC_LUI:   base_op[35] = 1'b1;
            OPC_AUIPC: base_op[36] = 1'b1;
            default: ;
        endcase
    end

    // M ops sit above the base map and only exist when the extension is built in
    if (EN_M != 0) begin : g_m
        logic [7:0] m_op;
        always_comb begin
            m_op = '0;
            if (opc == OPC_R && f7 == 7'h01) m_op[f3] = 1'b1;
        end
        assign dec_op = {m_op, base_op};
    end else begin : g_no_m
        assign dec_op = base_op;
    end

    always_comb begin
        is_r    = (opc == OPC_R);
        is_i    = (opc == OPC_IALU) || (opc == OPC_LOAD) || (opc == OPC_JALR);
        is_s    = (opc == OPC_STORE);
        is_b    = (opc == OPC_BRANCH);
        is_u    = (opc == OPC_LUI) || (opc == OPC_AUIPC);
        is_j    = (opc == OPC_JAL);
        dec_ill = ~|dec_op;

        if (is_i)      imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        else if (is_s) imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        else if (is_b) imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                in_instr[30:25], in_instr[11:8], 1'b0};
        else if (is_u) imm32 = {in_instr[31:12], 12'b0};
        else if (is_j) imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                in_instr[20], in_instr[30:21], 1'b0};
        else           imm32 = '0;

        dec.pc      = in_pc;
        dec.rd      = in_instr[11:7];
        dec.rs1     = in_instr[19:15];
        dec.rs2     = in_instr[24:20];
        dec.rd_v    = (is_r | is_i | is_u | is_j) & ~dec_ill;
        dec.rs1_v   = (is_r | is_i | is_s | is_b) & ~dec_ill;
        dec.rs2_v   = (is_r | is_s | is_b) & ~dec_ill;
        dec.imm_v   = ~is_r & ~dec_ill;
        dec.imm     = (dec_ill | is_r) ? '0 : XLEN'(imm32);
        dec.op      = dec_op;
        dec.illegal = dec_ill;
    end

    state_e state_q, state_d;
    dec_t   out_q, out_d, skid_q, skid_d;
    logic   in_ready_q;
    logic   in_xfer, out_xfer;

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = (state_q != EMPTY) & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            out_q      <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != TWO);
            out_q      <= out_d;
            skid_q     <= skid_d;
        end
    end

    // Flush beats every transfer; TWO never sees an input because in_ready is low there
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            out_d   = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_d = ONE;
                        out_d   = dec;
                    end
                end
                ONE: begin
                    if (in_xfer && !out_xfer) begin
                        state_d = TWO;
                        skid_d  = dec;
                    end else if (in_xfer) begin
                        out_d = dec;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        state_d = ONE;
                        out_d   = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        out_valid     = (state_q != EMPTY);
        in_ready      = in_ready_q;
        out_pc        = out_q.pc;
        out_rd        = out_q.rd;
        out_rs1       = out_q.rs1;
        out_rs2       = out_q.rs2;
        out_rd_valid  = out_q.rd_v;
        out_rs1_valid = out_q.rs1_v;
        out_rs2_valid = out_q.rs2_v;
        out_imm_valid = out_q.imm_v;
        out_imm       = out_q.imm;
        out_op        = out_q.op;
        out_illegal   = out_q.illegal;
    end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: one RV32+M instance and one RV64-without-M instance
// share stimulus; each is checked against a table-driven decode model and a queue.
module tb_decode_stage;

    logic        clk, rst, flush, in_valid, out_ready;
    logic [31:0] instr;
    logic [63:0] pc;

    logic        a_in_ready, a_out_valid, a_rdv, a_rs1v, a_rs2v, a_immv, a_ill;
    logic [31:0] a_pc, a_imm;
    logic [4:0]  a_rd, a_rs1, a_rs2;
    logic [44:0] a_op;

    logic        b_in_ready, b_out_valid, b_rdv, b_rs1v, b_rs2v, b_immv, b_ill;
    logic [63:0] b_pc, b_imm;
    logic [4:0]  b_rd, b_rs1, b_rs2;
    logic [36:0] b_op;

    decode_stage #(.XLEN(32), .EN_M(1)) u_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(instr), .in_pc(pc[31:0]), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_pc(a_pc), .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2),
        .out_rd_valid(a_rdv), .out_rs1_valid(a_rs1v), .out_rs2_valid(a_rs2v),
        .out_imm_valid(a_immv), .out_imm(a_imm), .out_op(a_op), .out_illegal(a_ill));

    decode_stage #(.XLEN(64), .EN_M(0)) u_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(instr), .in_pc(pc), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_pc(b_pc), .out_rd(b_rd), .out_rs1(b_rs1), .out_rs2(b_rs2),
        .out_rd_valid(b_rdv), .out_rs1_valid(b_rs1v), .out_rs2_valid(b_rs2v),
        .out_imm_valid(b_immv), .out_imm(b_imm), .out_op(b_op), .out_illegal(b_ill));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

    int checks = 0;
    int errors = 0;

    // Operation table: opcode, funct3 (-1 = any), funct7 (-1 = any) for each out_op bit
    int t_opc[45], t_f3[45], t_f7[45];

    typedef struct { logic [31:0] ins; logic [63:0] pc; } item_t;
    item_t sbq[$];
    bit    exp_ready;
    bit    zero_data;

    typedef struct {
        logic [31:0] ins;
        int          op_a;
        int          op_b;
        logic [63:0] imm;
        logic [3:0]  fl_a;
        logic [3:0]  fl_b;
    } vec_t;
    vec_t vt[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic def_op(input int k, input int o, input int f3, input int f7);
        t_opc[k] = o;
        t_f3[k]  = f3;
        t_f7[k]  = f7;
    endtask

    function automatic byte fmt_of(input int o);
        case (o)
            'h33:             return "R";
            'h13, 'h03, 'h67: return "I";
            'h23:             return "S";
            'h63:             return "B";
            'h37, 'h17:       return "U";
            'h6F:             return "J";
            default:          return "X";
        endcase
    endfunction

    function automatic void model(input logic [31:0] ins, input bit en_m, output int opi,
                                  output logic [63:0] imm64, output logic [3:0] fl);
        int o, f3, f7;
        byte t;
        longint s, v;
        o  = int'(ins[6:0]);
        f3 = int'(ins[14:12]);
        f7 = int'(ins[31:25]);
        opi = -1;
        for (int k = 0; k < 45; k++) begin
            if (k >= 37 && !en_m) continue;
            if (t_opc[k] == o && (t_f3[k] < 0 || t_f3[k] == f3) && (t_f7[k] < 0 || t_f7[k] == f7))
                opi = k;
        end
        t = fmt_of(o);
        s = longint'($signed(ins));
        case (t)
            "I": v = s >>> 20;
            "S": v = ((s >>> 25) <<< 5) | longint'(ins[11:7]);
            "B": v = ((s >>> 31) <<< 12) | (longint'(ins[7]) << 11) |
                     (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
            "U": v = longint'($signed(ins & 32'hFFFFF000));
            "J": v = ((s >>> 31) <<< 20) | (longint'(ins[19:12]) << 12) |
                     (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
            default: v = 0;
        endcase
        if (opi < 0) begin
            imm64 = '0;
            fl    = '0;
        end else begin
            imm64 = 64'(v);
            fl[3] = (t == "R" || t == "I" || t == "U" || t == "J");
            fl[2] = (t == "R" || t == "I" || t == "S" || t == "B");
            fl[1] = (t == "R" || t == "S" || t == "B");
            fl[0] = (t != "R");
        end
    endfunction

    task automatic get_act(input int which, output logic [63:0] op, output logic [63:0] imm,
                           output logic [63:0] p, output logic [14:0] idx,
                           output logic [3:0] fl, output logic ill);
        if (which == 0) begin
            op = 64'(a_op); imm = 64'(a_imm); p = 64'(a_pc);
            idx = {a_rd, a_rs1, a_rs2}; fl = {a_rdv, a_rs1v, a_rs2v, a_immv}; ill = a_ill;
        end else begin
            op = 64'(b_op); imm = b_imm; p = b_pc;
            idx = {b_rd, b_rs1, b_rs2}; fl = {b_rdv, b_rs1v, b_rs2v, b_immv}; ill = b_ill;
        end
    endtask

    // Compare one DUT's output register against the model's decode of a queued item
    task automatic cmp_dut(input string tag, input int which, input item_t it);
        int          opi;
        logic [63:0] eimm, mask, aop, aimm, apc;
        logic [14:0] aidx;
        logic [3:0]  efl, afl;
        logic        aill;
        mask = (which == 0) ? 64'h0000_0000_FFFF_FFFF : '1;
        model(it.ins, which == 0, opi, eimm, efl);
        get_act(which, aop, aimm, apc, aidx, afl, aill);
        chk({tag, "_op"},   aop, (opi >= 0) ? (64'd1 << opi) : 64'd0);
        chk({tag, "_imm"},  aimm, eimm & mask);
        chk({tag, "_pc"},   apc, it.pc & mask);
        chk({tag, "_idx"},  64'(aidx), 64'({it.ins[11:7], it.ins[19:15], it.ins[24:20]}));
        chk({tag, "_flag"}, 64'(afl), 64'(efl));
        chk({tag, "_ill"},  64'(aill), 64'(opi < 0));
    endtask

    task automatic check_zero(input int which);
        logic [63:0] aop, aimm, apc;
        logic [14:0] aidx;
        logic [3:0]  afl;
        logic        aill;
        get_act(which, aop, aimm, apc, aidx, afl, aill);
        chk((which == 0) ? "zero_a" : "zero_b", {aop[31:0] | aimm[31:0], apc[31:0] | 28'(afl)},
            64'd0);
    endtask

    // One clock: check outputs against the queue, then advance the queue by the edge
    task automatic tick();
        bit in_x, out_x;
        item_t it;
        chk("out_valid_a", 64'(a_out_valid), 64'(sbq.size() > 0));
        chk("out_valid_b", 64'(b_out_valid), 64'(sbq.size() > 0));
        chk("in_ready_a",  64'(a_in_ready),  64'(exp_ready));
        chk("in_ready_b",  64'(b_in_ready),  64'(exp_ready));
        if (sbq.size() > 0) begin
            cmp_dut("sb_a", 0, sbq[0]);
            cmp_dut("sb_b", 1, sbq[0]);
        end else if (zero_data) begin
            check_zero(0);
            check_zero(1);
        end
        in_x  = in_valid && exp_ready;
        out_x = (sbq.size() > 0) && out_ready;
        it.ins = instr;
        it.pc  = pc;
        @(posedge clk);
        if (flush) begin
            sbq.delete();
            zero_data = 1'b1;
        end else begin
            if (out_x) void'(sbq.pop_front());
            if (in_x) begin
                sbq.push_back(it);
                zero_data = 1'b0;
            end
        end
        exp_ready = (sbq.size() < 2);
        #1;
    endtask

    task automatic vec_check(input int n);
        logic [63:0] aop, aimm, apc;
        logic [14:0] aidx;
        logic [3:0]  afl;
        logic        aill;
        for (int w = 0; w < 2; w++) begin
            int opx;
            opx = (w == 0) ? vt[n].op_a : vt[n].op_b;
            get_act(w, aop, aimm, apc, aidx, afl, aill);
            chk($sformatf("vec%0d_%0d_valid", n, w), 64'((w == 0) ? a_out_valid : b_out_valid), 64'd1);
            chk($sformatf("vec%0d_%0d_op", n, w), aop, (opx >= 0) ? (64'd1 << opx) : 64'd0);
            chk($sformatf("vec%0d_%0d_imm", n, w), aimm,
                (w == 0) ? (vt[n].imm & 64'hFFFF_FFFF) : vt[n].imm);
            chk($sformatf("vec%0d_%0d_flag", n, w), 64'(afl), 64'((w == 0) ? vt[n].fl_a : vt[n].fl_b));
            chk($sformatf("vec%0d_%0d_ill", n, w), 64'(aill), 64'(opx < 0));
            chk($sformatf("vec%0d_%0d_rd", n, w), 64'(aidx[14:10]), 64'(vt[n].ins[11:7]));
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int          sel;
        logic [6:0]  opcs [9];
        opcs = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
        r   = $urandom;
        sel = $urandom_range(0, 9);
        if (sel < 9) r[6:0] = opcs[sel];
        case ($urandom_range(0, 3))
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            2: r[31:25] = 7'h01;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        for (int k = 0; k < 10; k++) def_op(k, 'h33, 0, 0);
        t_f7[1] = 'h20; t_f7[7] = 'h20;
        t_f3[2] = 4; t_f3[3] = 6; t_f3[4] = 7; t_f3[5] = 1; t_f3[6] = 5; t_f3[7] = 5;
        t_f3[8] = 2; t_f3[9] = 3;
        def_op(10, 'h13, 0, -1); def_op(11, 'h13, 4, -1); def_op(12, 'h13, 6, -1);
        def_op(13, 'h13, 7, -1); def_op(14, 'h13, 1, 0);  def_op(15, 'h13, 5, 0);
        def_op(16, 'h13, 5, 'h20); def_op(17, 'h13, 2, -1); def_op(18, 'h13, 3, -1);
        def_op(19, 'h03, 0, -1); def_op(20, 'h03, 1, -1); def_op(21, 'h03, 2, -1);
        def_op(22, 'h03, 4, -1); def_op(23, 'h03, 5, -1);
        def_op(24, 'h23, 0, -1); def_op(25, 'h23, 1, -1); def_op(26, 'h23, 2, -1);
        def_op(27, 'h63, 0, -1); def_op(28, 'h63, 1, -1); def_op(29, 'h63, 4, -1);
        def_op(30, 'h63, 5, -1); def_op(31, 'h63, 6, -1); def_op(32, 'h63, 7, -1);
        def_op(33, 'h6F, -1, -1); def_op(34, 'h67, 0, -1);
        def_op(35, 'h37, -1, -1); def_op(36, 'h17, -1, -1);
        for (int k = 37; k < 45; k++) def_op(k, 'h33, k - 37, 1);

        vt[0]  = '{32'h00500093, 10, 10, 64'd5,                   4'b1101, 4'b1101};
        vt[1]  = '{32'h402081B3, 1,  1,  64'd0,                   4'b1110, 4'b1110};
        vt[2]  = '{32'hFE000EE3, 27, 27, 64'hFFFF_FFFF_FFFF_FFFC, 4'b0111, 4'b0111};
        vt[3]  = '{32'h027302B3, 37, -1, 64'd0,                   4'b1110, 4'b0000};
        vt[4]  = '{32'h12345537, 35, 35, 64'h0000_0000_1234_5000, 4'b1001, 4'b1001};
        vt[5]  = '{32'h800000B7, 35, 35, 64'hFFFF_FFFF_8000_0000, 4'b1001, 4'b1001};
        vt[6]  = '{32'h00001297, 36, 36, 64'h0000_0000_0000_1000, 4'b1001, 4'b1001};
        vt[7]  = '{32'hFFDFF0EF, 33, 33, 64'hFFFF_FFFF_FFFF_FFFC, 4'b1001, 4'b1001};
        vt[8]  = '{32'h0020A423, 26, 26, 64'd8,                   4'b0111, 4'b0111};
        vt[9]  = '{32'h40335293, 16, 16, 64'h403,                 4'b1101, 4'b1101};
        vt[10] = '{32'hFFF1A203, 21, 21, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1101, 4'b1101};
        vt[11] = '{32'h00000000, -1, -1, 64'd0,                   4'b0000, 4'b0000};
        vt[12] = '{32'hFFFFFFFF, -1, -1, 64'd0,                   4'b0000, 4'b0000};
        vt[13] = '{32'h40209133, -1, -1, 64'd0,                   4'b0000, 4'b0000};
        vt[14] = '{32'h00008067, 34, 34, 64'd0,                   4'b1101, 4'b1101};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        instr = 32'h0; pc = 64'h0;
        sbq.delete(); exp_ready = 1'b1; zero_data = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        for (int n = 0; n < 15; n++) begin
            instr = vt[n].ins; pc = 64'h8000_0000_0000_1000 + 64'(n * 4); in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            vec_check(n);
            tick();
        end

        in_valid = 1'b1; instr = 32'h402081B3; pc = 64'h100;
        tick();
        instr = 32'hFE000EE3; pc = 64'h104;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();

        out_ready = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            instr = vt[k].ins; pc = 64'h200 + 64'(k * 4);
            tick();
        end
        in_valid = 1'b0;
        chk("bp_in_ready_low", 64'(a_in_ready), 64'd0);
        chk("bp_held_valid", 64'(a_out_valid), 64'd1);
        tick();
        out_ready = 1'b1;
        repeat (3) tick();

        out_ready = 1'b0; in_valid = 1'b1;
        for (int k = 3; k < 6; k++) begin
            instr = vt[k].ins; pc = 64'h300 + 64'(k * 4);
            tick();
        end
        flush = 1'b1; instr = vt[6].ins;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("flush_valid", 64'(b_out_valid), 64'd0);
        chk("flush_ready", 64'(b_in_ready), 64'd1);
        repeat (3) tick();

        out_ready = 1'b0; in_valid = 1'b1; instr = vt[0].ins; pc = 64'h400;
        tick();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_valid_a", 64'(a_out_valid), 64'd0);
        chk("arst_valid_b", 64'(b_out_valid), 64'd0);
        chk("arst_op_a", 64'(a_op), 64'd0);
        sbq.delete(); exp_ready = 1'b1; zero_data = 1'b1;
        rst = 1'b0; out_ready = 1'b1;
        repeat (3) tick();

        for (int c = 0; c < 600; c++) begin
            flush     = ($urandom_range(0, 99) < 3);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            instr     = rand_instr();
            pc        = {$urandom, $urandom};
            tick();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
